// File: rtl/fir_pkg.sv
// Shared FIR datapath constants and width helpers.
package fir_pkg;
  localparam int FIR_TAPS = 16;
  localparam int FIR_N    = 13;
  localparam int FIR_M    = 12;
  localparam int FIR_PW   = FIR_N + FIR_M;

  // A sum of taps products of pw bits needs clog2(taps) growth bits.
  function automatic int fir_sum_w(input int pw, input int taps);
    return pw + $clog2(taps);
  endfunction
endpackage

// File: rtl/fir_acc_fifo2.sv
// Two-entry in-order FIFO. A push into a full FIFO without a same-cycle
// pop is dropped and reported on drop; the head register holds when empty.
module fir_acc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  logic [W-1:0] r_head, r_tail;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign w_pop = pop & (r_cnt != 2'd0);
  assign empty = (r_cnt == 2'd0);
  assign full  = (r_cnt == 2'd2);
  assign drop  = push & full & ~w_pop;
  assign dout  = r_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else if (w_pop) begin
      if (r_cnt == 2'd2) r_head <= r_tail;
      // With a pop, the new sample lands where the survivor count points.
      if (push) begin
        if (r_cnt == 2'd1) r_head <= din;
        else               r_tail <= din;
      end
      r_cnt <= r_cnt - 2'd1 + {1'b0, push};
    end else if (push) begin
      case (r_cnt)
        2'd0:    begin r_head <= din; r_cnt <= 2'd1; end
        2'd1:    begin r_tail <= din; r_cnt <= 2'd2; end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fir_acc.sv
// FIR output accumulator: sums TAPS products per sample into a 2-entry buffer.
// Optional clamping to OUT_W with a sat pulse under FIR_ACC_SAT_EN.
module fir_acc
  import fir_pkg::*;
#(
  parameter int PW    = FIR_PW,
  parameter int TAPS  = FIR_TAPS,
  parameter int OUT_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     prod_vld,
  input  logic [PW-1:0]            prod,
  output logic                     out_vld,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     out_rdy,
  output logic [$clog2(TAPS)-1:0]  tap_cnt,
  output logic                     ovf,
  output logic                     sat
);
  localparam int SW = fir_sum_w(PW, TAPS);
  localparam int CW = $clog2(TAPS);
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

  logic [SW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [SW-1:0]    w_sum;
  logic             w_last, w_hi_nz;
  logic [OUT_W-1:0] w_conv;
  logic             w_empty, w_full, w_drop, w_pop;
  logic             w_unused;

  assign w_sum   = r_acc + SW'(prod);
  assign w_last  = prod_vld & ~clr & (r_cnt == LAST);
  assign w_hi_nz = |w_sum[SW-1:OUT_W];
  assign w_pop   = out_vld & out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      // A product arriving with clr seeds the new sum.
      r_acc <= prod_vld ? SW'(prod) : '0;
      r_cnt <= prod_vld ? CW'(1) : '0;
    end else if (prod_vld) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else     r_ovf <= r_ovf | w_drop;
  end

`ifdef FIR_ACC_SAT_EN
  logic r_sat;
  assign w_conv   = w_hi_nz ? '1 : w_sum[OUT_W-1:0];
  assign w_unused = w_full;
  always_ff @(posedge clk) begin
    if (rst) r_sat <= 1'b0;
    else     r_sat <= w_last & w_hi_nz;
  end
  assign sat = r_sat;
`else
  assign w_conv   = w_sum[OUT_W-1:0];
  assign w_unused = ^{w_hi_nz, w_full};
  assign sat      = 1'b0;
`endif

  fir_acc_fifo2 #(.W(OUT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_last),
    .din   (w_conv),
    .pop   (w_pop),
    .dout  (out_data),
    .empty (w_empty),
    .full  (w_full),
    .drop  (w_drop)
  );

  assign out_vld = ~w_empty;
  assign tap_cnt = r_cnt;
  assign ovf     = r_ovf;
endmodule

// File: tb/tb_fir_acc.sv
// Directed bench for fir_acc with TAPS=4, OUT_W=8.
module tb_fir_acc;
  localparam int PW = 25, TAPS = 4, OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst, clr, prod_vld, out_rdy;
  logic [PW-1:0]    prod;
  logic             out_vld, ovf, sat;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       tap_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_acc #(.PW(PW), .TAPS(TAPS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .prod_vld(prod_vld), .prod(prod),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
    .tap_cnt(tap_cnt), .ovf(ovf), .sat(sat)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p);
    prod_vld = 1'b1;
    prod     = PW'(p);
    tick();
    prod_vld = 1'b0;
    prod     = '0;
  endtask

  task automatic pop1();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; prod_vld = 1'b0; prod = '0; out_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_cnt", 32'(tap_cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_sat", 32'(sat), 0);

    // back-to-back 1,2,3,4
    send(1); send(2); send(3);
    chk("t1_cnt3", 32'(tap_cnt), 3);
    chk("t1_vld_early", 32'(out_vld), 0);
    send(4);
    chk("t1_vld", 32'(out_vld), 1);
    chk("t1_data", 32'(out_data), 10);
    chk("t1_cnt0", 32'(tap_cnt), 0);
    pop1();
    chk("t1_vld_pop", 32'(out_vld), 0);
    chk("t1_hold", 32'(out_data), 10);

    // gapped products
    for (int i = 0; i < 4; i++) begin
      send(5); tick(); tick();
    end
    chk("t2_vld", 32'(out_vld), 1);
    chk("t2_data", 32'(out_data), 20);
    pop1();

    // overflow: three samples with no consumer
    for (int i = 1; i <= 8; i++) send(i);
    chk("t3_ovf_pre", 32'(ovf), 0);
    for (int i = 9; i <= 12; i++) send(i);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_head", 32'(out_data), 10);
    pop1();
    chk("t3_vld2", 32'(out_vld), 1);
    chk("t3_second", 32'(out_data), 26);
    pop1();
    chk("t3_empty", 32'(out_vld), 0);
    chk("t3_ovf_sticky", 32'(ovf), 1);

    // clr alone, then clr with a product
    send(3); send(3);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_clr_cnt", 32'(tap_cnt), 0);
    send(3); send(3);
    clr = 1'b1; send(7); clr = 1'b0;
    chk("t4_seed_cnt", 32'(tap_cnt), 1);
    chk("t4_no_vld", 32'(out_vld), 0);
    send(1); send(1); send(1);
    chk("t4_vld", 32'(out_vld), 1);
    chk("t4_data", 32'(out_data), 10);
    pop1();

    // sum of 300 into 8 bits
    send(100); send(100); send(50); send(50);
    chk("t5_vld", 32'(out_vld), 1);
`ifdef FIR_ACC_SAT_EN
    chk("t5_data", 32'(out_data), 255);
    chk("t5_sat", 32'(sat), 1);
`else
    chk("t5_data", 32'(out_data), 44);
    chk("t5_sat", 32'(sat), 0);
`endif
    pop1();
    chk("t5_sat_off", 32'(sat), 0);

    // reset mid-sample with a sample buffered
    send(1); send(2); send(3); send(4);
    send(5); send(6);
    chk("t6_pre_vld", 32'(out_vld), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_vld", 32'(out_vld), 0);
    chk("t6_data", 32'(out_data), 0);
    chk("t6_cnt", 32'(tap_cnt), 0);
    chk("t6_ovf", 32'(ovf), 0);
    send(1); send(2); send(3); send(4);
    chk("t6_new_vld", 32'(out_vld), 1);
    chk("t6_new_data", 32'(out_data), 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
